dma_desc_sched: RTL and testbench

- Multi-channel descriptor queue and launcher in front of the single-channel DMA function wrapper.
- Replaces hand-sequenced go/desc/wait-for-done driving with NUM_CH independent descriptor FIFOs.
- A round-robin scheduler issues one descriptor at a time as a one-cycle go pulse, then waits for done or error.
- Reports completion per channel; on error, halts issue until software clears it.

---
 rtl/dma_desc_sched_if.sv | 41 ++++
 rtl/dma_desc_sched.sv | 172 +++++++++++++++++
 tb/tb_dma_desc_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_desc_sched_if.sv
// Descriptor-queue scheduler bus: per-channel push side, DMA launch side, error control.
// Master drives pushes/DMA status, slave is the scheduler; all handshakes are level signals.
interface dma_desc_sched_if #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        ch_valid_i;
    logic [NUM_CH-1:0]        ch_ready_o;
    logic [NUM_CH*ADDR_W-1:0] ch_src_i;
    logic [NUM_CH*ADDR_W-1:0] ch_dst_i;
    logic [NUM_CH*LEN_W-1:0]  ch_len_i;
    logic [NUM_CH*LVL_W-1:0]  ch_level_o;
    logic [NUM_CH-1:0]        ch_done_o;
    logic                     dma_go_o;
    logic [ADDR_W-1:0]        dma_src_o;
    logic [ADDR_W-1:0]        dma_dst_o;
    logic [LEN_W-1:0]         dma_len_o;
    logic                     dma_done_i;
    logic                     dma_error_i;
    logic                     busy_o;
    logic                     err_o;
    logic [CH_W-1:0]          err_ch_o;
    logic                     clr_err_i;

    modport slave (
        input  ch_valid_i, ch_src_i, ch_dst_i, ch_len_i, dma_done_i, dma_error_i, clr_err_i,
        output ch_ready_o, ch_level_o, ch_done_o, dma_go_o, dma_src_o, dma_dst_o, dma_len_o,
               busy_o, err_o, err_ch_o
    );

    modport master (
        output ch_valid_i, ch_src_i, ch_dst_i, ch_len_i, dma_done_i, dma_error_i, clr_err_i,
        input  ch_ready_o, ch_level_o, ch_done_o, dma_go_o, dma_src_o, dma_dst_o, dma_len_o,
               busy_o, err_o, err_ch_o
    );
endinterface

// File: rtl/dma_desc_sched.sv
// Per-channel descriptor FIFOs + round-robin launcher for one DMA engine; push->go 2 cycles.
// Push backpressure from registered FIFO full only; one descriptor in flight, HALT on error.
module dma_desc_sched #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32
) (
    input logic               clk,
    input logic               rst,
    dma_desc_sched_if.slave   sched_bus
);
    localparam int AIW   = $clog2(DEPTH);
    localparam int PW    = AIW + 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_nonempty;
    logic [NUM_CH-1:0]   w_push;
    logic [2*NUM_CH-1:0] w_ne2;
    logic [NUM_CH-1:0]   w_rot;
    logic [ADDR_W-1:0]   w_head_src [NUM_CH];
    logic [ADDR_W-1:0]   w_head_dst [NUM_CH];
    logic [LEN_W-1:0]    w_head_len [NUM_CH];
    logic                w_any;
    logic                w_pop;
    int                  w_off;
    int                  w_sum;
    logic [CHW-1:0]      w_grant;
    logic [CHW-1:0]      w_rr_next;

    logic [1:0]          r_state;
    logic [CHW-1:0]      r_rr;
    logic [CHW-1:0]      r_grant;
    logic [CHW-1:0]      r_err_ch;
    logic                r_go;
    logic                r_err;
    logic [NUM_CH-1:0]   r_done;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_len;

    assign w_pop = (r_state == S_IDLE) && w_any;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0]     r_wr;
        logic [PW-1:0]     r_rd;
        logic [ADDR_W-1:0] r_src_mem [DEPTH];
        logic [ADDR_W-1:0] r_dst_mem [DEPTH];
        logic [LEN_W-1:0]  r_len_mem [DEPTH];

        // Full when the pointers differ only in the wrap bit.
        assign w_full[c]     = (r_wr[AIW-1:0] == r_rd[AIW-1:0]) && (r_wr[PW-1] != r_rd[PW-1]);
        assign w_nonempty[c] = (r_wr != r_rd);
        assign w_push[c]     = sched_bus.ch_valid_i[c] && !w_full[c];
        assign sched_bus.ch_ready_o[c] = !w_full[c];
        assign sched_bus.ch_level_o[c*LVL_W +: LVL_W] = LVL_W'(r_wr - r_rd);
        assign w_head_src[c] = r_src_mem[r_rd[AIW-1:0]];
        assign w_head_dst[c] = r_dst_mem[r_rd[AIW-1:0]];
        assign w_head_len[c] = r_len_mem[r_rd[AIW-1:0]];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push[c])
                    r_wr <= r_wr + PW'(1);
                if (w_pop && (w_grant == CHW'(c)))
                    r_rd <= r_rd + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[c]) begin
                r_src_mem[r_wr[AIW-1:0]] <= sched_bus.ch_src_i[c*ADDR_W +: ADDR_W];
                r_dst_mem[r_wr[AIW-1:0]] <= sched_bus.ch_dst_i[c*ADDR_W +: ADDR_W];
                r_len_mem[r_wr[AIW-1:0]] <= sched_bus.ch_len_i[c*LEN_W +: LEN_W];
            end
        end
    end

    // Rotate non-empty mask so bit 0 is rr_ptr; lowest set bit is the grant offset.
    assign w_ne2 = {w_nonempty, w_nonempty};
    assign w_rot = NUM_CH'(w_ne2 >> r_rr);

    always_comb begin
        w_any = 1'b0;
        w_off = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_off = i;
            end
        end
        w_sum = int'(r_rr) + w_off;
        if (w_sum >= NUM_CH)
            w_sum = w_sum - NUM_CH;
        w_grant = CHW'(w_sum);
    end

    assign w_rr_next = (w_grant == CHW'(NUM_CH - 1)) ? '0 : w_grant + CHW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_grant  <= '0;
            r_err_ch <= '0;
            r_go     <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
        end else begin
            r_go   <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_src   <= w_head_src[w_grant];
                        r_dst   <= w_head_dst[w_grant];
                        r_len   <= w_head_len[w_grant];
                        r_grant <= w_grant;
                        r_rr    <= w_rr_next;
                        // Zero-length descriptors complete without touching the DMA.
                        if (w_head_len[w_grant] == '0) begin
                            r_done[w_grant] <= 1'b1;
                        end else begin
                            r_go    <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (sched_bus.dma_error_i) begin
                        r_err    <= 1'b1;
                        r_err_ch <= r_grant;
                        r_state  <= S_HALT;
                    end else if (sched_bus.dma_done_i) begin
                        r_done[r_grant] <= 1'b1;
                        r_state         <= S_IDLE;
                    end
                end
                S_HALT: begin
                    if (sched_bus.clr_err_i) begin
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sched_bus.dma_go_o  = r_go;
    assign sched_bus.dma_src_o = r_src;
    assign sched_bus.dma_dst_o = r_dst;
    assign sched_bus.dma_len_o = r_len;
    assign sched_bus.ch_done_o = r_done;
    assign sched_bus.busy_o    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign sched_bus.err_o     = r_err;
    assign sched_bus.err_ch_o  = r_err_ch;
endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: expected launches/completions are queued by the stimulus
// and a negedge monitor pops and compares them whenever the DUT pulses go or done.
module tb_dma_desc_sched;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 32;
    localparam int LVL_W  = 4;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_desc_sched_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();
    dma_desc_sched #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sched_bus (bus)
    );

    desc_t exp_go[$];
    int    exp_done[$];
    desc_t mon_e;
    int    mon_d;
    int    checks    = 0;
    int    errors    = 0;
    int    n_go      = 0;
    int    n_go_exp  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dma_go_o) begin
                n_go++;
                checks++;
                if (exp_go.size() == 0) begin
                    errors++;
                    $display("FAIL go_unexpected: got go with src 0x%0h, no launch expected", bus.dma_src_o);
                end else begin
                    mon_e = exp_go.pop_front();
                    chk("go_src", bus.dma_src_o, mon_e.src);
                    chk("go_dst", bus.dma_dst_o, mon_e.dst);
                    chk("go_len", bus.dma_len_o, mon_e.len);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.ch_done_o[c]) begin
                    checks++;
                    if (exp_done.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: got done on ch %0d, none expected", c);
                    end else begin
                        mon_d = exp_done.pop_front();
                        if (c != mon_d) begin
                            errors++;
                            $display("FAIL done_ch: got ch %0d expected ch %0d", c, mon_d);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.ch_valid_i = '0;
    endtask

    task automatic set_desc(input int c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        bus.ch_valid_i[c]          = 1'b1;
        bus.ch_src_i[c*32 +: 32]   = s;
        bus.ch_dst_i[c*32 +: 32]   = d;
        bus.ch_len_i[c*32 +: 32]   = l;
    endtask

    task automatic push1(input int c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        set_desc(c, s, d, l);
        tick();
    endtask

    task automatic expect_go(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        exp_go.push_back({s, d, l});
        n_go_exp++;
    endtask

    task automatic expect_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, input int c);
        expect_go(s, d, l);
        exp_done.push_back(c);
    endtask

    function automatic logic [LVL_W-1:0] level(input int c);
        return bus.ch_level_o[c*LVL_W +: LVL_W];
    endfunction

    task automatic wait_go();
        int n = 0;
        while (!bus.dma_go_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("go_seen", bus.dma_go_o, 1);
    endtask

    task automatic pulse_done();
        bus.dma_done_i = 1'b1;
        @(posedge clk);
        #1;
        bus.dma_done_i = 1'b0;
    endtask

    task automatic service(input int n);
        wait_go();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        pulse_done();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.ch_valid_i  = '0;
        bus.ch_src_i    = '0;
        bus.ch_dst_i    = '0;
        bus.ch_len_i    = '0;
        bus.dma_done_i  = 1'b0;
        bus.dma_error_i = 1'b0;
        bus.clr_err_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.ch_ready_o, 4'hF);
        chk("rst_level", bus.ch_level_o, 16'h0);
        chk("rst_go", bus.dma_go_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_err_ch", bus.err_ch_o, 0);
        chk("rst_done", bus.ch_done_o, 0);
        chk("rst_src", bus.dma_src_o, 0);
        rst = 1'b0;
        tick();

        // Single descriptor: go exactly 2 cycles after the push edge.
        expect_xfer(32'h0, 32'h1100_0000, 32'h30, 0);
        push1(0, 32'h0, 32'h1100_0000, 32'h30);
        chk("t1_go_early", bus.dma_go_o, 0);
        tick();
        chk("t1_go_lat2", bus.dma_go_o, 1);
        chk("t1_busy", bus.busy_o, 1);
        tick();
        chk("t1_go_one_cycle", bus.dma_go_o, 0);
        repeat (9) tick();
        pulse_done();
        chk("t1_done_pulse", bus.ch_done_o, 4'b0001);
        chk("t1_busy_drop", bus.busy_o, 0);
        tick();
        chk("t1_done_one_cycle", bus.ch_done_o, 0);
        chk("t1_len_hold", bus.dma_len_o, 32'h30);

        // Round robin across four channels, two descriptors each.
        do_reset();
        for (int c = 0; c < 4; c++)
            expect_xfer(32'hA000_0000 | (c << 8), 32'hB000_0000 | (c << 8), 32'h40 + c, c);
        for (int c = 0; c < 4; c++)
            expect_xfer(32'hA000_0001 | (c << 8), 32'hB000_0001 | (c << 8), 32'h80 + c, c);
        for (int c = 0; c < 4; c++)
            set_desc(c, 32'hA000_0000 | (c << 8), 32'hB000_0000 | (c << 8), 32'h40 + c);
        tick();
        for (int c = 0; c < 4; c++)
            set_desc(c, 32'hA000_0001 | (c << 8), 32'hB000_0001 | (c << 8), 32'h80 + c);
        tick();
        repeat (8) service(3);

        // Fill ch2 while the DMA is stalled.
        expect_xfer(32'h2000, 32'h3000, 32'h10, 2);
        push1(2, 32'h2000, 32'h3000, 32'h10);
        wait_go();
        for (int i = 0; i < 8; i++) begin
            expect_xfer(32'h2100 + i, 32'h3100 + i, 32'h20 + i, 2);
            push1(2, 32'h2100 + i, 32'h3100 + i, 32'h20 + i);
        end
        chk("t3_ready_full", bus.ch_ready_o[2], 0);
        chk("t3_level8", level(2), 8);
        push1(2, 32'hDEAD, 32'hBEEF, 32'h99);
        chk("t3_level_no_9th", level(2), 8);
        pulse_done();
        chk("t3_ready_before_pop", bus.ch_ready_o[2], 0);
        tick();
        chk("t3_ready_after_pop", bus.ch_ready_o[2], 1);
        chk("t3_level7", level(2), 7);
        chk("t3_go_next", bus.dma_go_o, 1);
        repeat (8) service(2);

        // Zero-length descriptor completes without a launch.
        exp_done.push_back(1);
        expect_xfer(32'h4000, 32'h5000, 32'h320, 1);
        push1(1, 32'h4100, 32'h5100, 32'h0);
        push1(1, 32'h4000, 32'h5000, 32'h320);
        chk("t4_zero_done", bus.ch_done_o, 4'b0010);
        chk("t4_zero_no_go", bus.dma_go_o, 0);
        service(4);

        // Error wins over done; halt until cleared.
        expect_go(32'h6000, 32'h7000, 32'h40);
        push1(3, 32'h6000, 32'h7000, 32'h40);
        wait_go();
        push1(0, 32'h6100, 32'h7100, 32'h50);
        bus.dma_error_i = 1'b1;
        pulse_done();
        bus.dma_error_i = 1'b0;
        chk("t5_err", bus.err_o, 1);
        chk("t5_err_ch", bus.err_ch_o, 3);
        chk("t5_busy", bus.busy_o, 0);
        chk("t5_no_done", bus.ch_done_o, 0);
        repeat (4) tick();
        chk("t5_held_level", level(0), 1);
        chk("t5_err_sticky", bus.err_o, 1);
        expect_xfer(32'h6100, 32'h7100, 32'h50, 0);
        bus.clr_err_i = 1'b1;
        tick();
        bus.clr_err_i = 1'b0;
        chk("t5_err_cleared", bus.err_o, 0);
        chk("t5_go_not_yet", bus.dma_go_o, 0);
        tick();
        chk("t5_go_after_clr", bus.dma_go_o, 1);
        service(2);

        // Reset in WAIT with three queued descriptors.
        expect_go(32'h8000, 32'h9000, 32'h80);
        push1(0, 32'h8000, 32'h9000, 32'h80);
        wait_go();
        for (int i = 0; i < 3; i++)
            push1(1, 32'h8100 + i, 32'h9100 + i, 32'h90);
        chk("t6_level_pre", level(1), 3);
        rst = 1'b1;
        #1;
        chk("t6_go_in_rst", bus.dma_go_o, 0);
        chk("t6_busy_in_rst", bus.busy_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_levels", bus.ch_level_o, 16'h0);
        chk("t6_ready", bus.ch_ready_o, 4'hF);
        chk("t6_err", bus.err_o, 0);
        chk("t6_go", bus.dma_go_o, 0);
        expect_xfer(32'h8800, 32'h9800, 32'h100, 1);
        push1(1, 32'h8800, 32'h9800, 32'h100);
        service(3);

        repeat (5) tick();
        chk("end_go_queue", exp_go.size(), 0);
        chk("end_done_queue", exp_done.size(), 0);
        chk("end_go_count", n_go, n_go_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
